// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data requesters
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [3:0]  streak_q;
  logic        kill_q;
  logic        owner_q;   // 0 = fetch, 1 = data

  logic idle_ok;
  logic starve;
  logic fetch_win;
  logic resp;

  always_comb begin
    // Reset gates the IDLE grants so outputs drop immediately on an async reset.
    idle_ok   = (state_q == S_IDLE) && !reset;
    starve    = (streak_q == 4'(STARVE_LIMIT));
    fetch_win = if_req && (!d_req || starve);
    resp      = (state_q == S_WAIT) && (cnt_q == 2'd0);

    if_gnt    = idle_ok && fetch_win;
    d_gnt     = idle_ok && d_req && !fetch_win;
    mem_en    = if_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_we ? d_wstrb : '0;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end

    // A kill arriving in the response cycle itself must still suppress the pulse.
    if_rvalid = resp && !owner_q && !kill_q && !if_kill;
    d_rvalid  = resp && owner_q;
    if_rdata  = (resp && !owner_q) ? mem_rdata : '0;
    d_rdata   = (resp && owner_q) ? mem_rdata : '0;
    busy      = (state_q == S_WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      streak_q <= 4'd0;
      kill_q   <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          kill_q <= 1'b0;
          if (if_gnt || d_gnt) begin
            state_q <= S_WAIT;
            cnt_q   <= 2'(MEM_LATENCY - 1);
            owner_q <= d_gnt;
          end
          if (if_gnt) begin
            streak_q <= 4'd0;
          end else if (d_gnt) begin
            if (!if_req)
              streak_q <= 4'd0;
            else if (!starve)
              streak_q <= streak_q + 4'd1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 2'd1;
            if (!owner_q && if_kill)
              kill_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter (latency 1 and 3 instances)
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_kill;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] mem_rdata;

  logic        a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;
  logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wstrb;

  int checks;
  int failures;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_lat1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wstrb(a_mem_wstrb), .mem_rdata(mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_lat3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wstrb(b_mem_wstrb), .mem_rdata(mem_rdata), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    if_req    = 1'b0;
    if_addr   = 32'h0;
    if_kill   = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    d_wstrb   = 4'h0;
    mem_rdata = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h1234;
    d_req   = 1'b1;
    d_addr  = 32'h5678;
    d_wdata = 32'hFFFF_FFFF;
    d_wstrb = 4'hF;
    d_we    = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_busy, a_if_rvalid, a_d_rvalid} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {a_if_gnt, a_d_gnt, a_mem_en, a_mem_we, a_busy, a_if_rvalid, a_d_rvalid});
    end
    checks++;
    if ({a_mem_addr, a_mem_wdata, a_mem_wstrb} !== 68'h0) begin
      failures++;
      $display("FAIL reset_mem_bus got addr=%h wdata=%h wstrb=%h exp=0", a_mem_addr, a_mem_wdata, a_mem_wstrb);
    end
    apply_reset();
  endtask

  task automatic test_single_fetch();
    apply_reset();
    if_req    = 1'b1;
    if_addr   = 32'h40;
    d_wstrb   = 4'hF;
    mem_rdata = 32'h0050_0093;
    @(negedge clk);
    checks++;
    if ({a_if_gnt, a_d_gnt, a_mem_en, a_mem_we} !== 4'b1010) begin
      failures++;
      $display("FAIL fetch_grant got gnt/dgnt/en/we=%b exp=1010", {a_if_gnt, a_d_gnt, a_mem_en, a_mem_we});
    end
    checks++;
    if (a_mem_addr !== 32'h40 || a_mem_wstrb !== 4'h0) begin
      failures++;
      $display("FAIL fetch_mem_bus got addr=%h wstrb=%h exp addr=40 wstrb=0", a_mem_addr, a_mem_wstrb);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({a_if_rvalid, a_if_gnt, a_mem_en, a_busy, a_d_rvalid} !== 5'b10010) begin
      failures++;
      $display("FAIL fetch_resp_ctrl got rv/gnt/en/busy/drv=%b exp=10010",
               {a_if_rvalid, a_if_gnt, a_mem_en, a_busy, a_d_rvalid});
    end
    checks++;
    if (a_if_rdata !== 32'h0050_0093 || a_d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL fetch_rdata got if=%h d=%h exp if=00500093 d=0", a_if_rdata, a_d_rdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({a_if_gnt, a_if_rvalid, a_busy} !== 3'b100) begin
      failures++;
      $display("FAIL fetch_next_grant got gnt/rv/busy=%b exp=100", {a_if_gnt, a_if_rvalid, a_busy});
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_starvation();
    int g;
    logic [1:0] exp_g;
    apply_reset();
    if_req = 1'b1;
    d_req  = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        g     = k / 2;
        exp_g = (g % 5 == 4) ? 2'b10 : 2'b01;
      end else begin
        exp_g = 2'b00;
      end
      checks++;
      if ({a_if_gnt, a_d_gnt} !== exp_g) begin
        failures++;
        $display("FAIL starve_order cycle=%0d got if/d=%b exp=%b", k, {a_if_gnt, a_d_gnt}, exp_g);
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_write();
    apply_reset();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hDEAD_BEEF;
    d_wstrb = 4'b0011;
    if_addr = 32'h999;
    @(negedge clk);
    checks++;
    if ({a_d_gnt, a_if_gnt, a_mem_en, a_mem_we, a_mem_wstrb} !== 8'b1011_0011) begin
      failures++;
      $display("FAIL write_grant got dgnt/ignt/en/we/wstrb=%b exp=10110011",
               {a_d_gnt, a_if_gnt, a_mem_en, a_mem_we, a_mem_wstrb});
    end
    checks++;
    if (a_mem_addr !== 32'h100 || a_mem_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL write_bus got addr=%h wdata=%h exp addr=100 wdata=deadbeef", a_mem_addr, a_mem_wdata);
    end
    next_cycle();
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_d_rvalid, a_if_rvalid, a_busy, a_mem_en} !== 4'b1010) begin
      failures++;
      $display("FAIL write_ack got drv/irv/busy/en=%b exp=1010", {a_d_rvalid, a_if_rvalid, a_busy, a_mem_en});
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({a_d_rvalid, a_if_rvalid, a_busy} !== 3'b000) begin
      failures++;
      $display("FAIL write_after got drv/irv/busy=%b exp=000", {a_d_rvalid, a_if_rvalid, a_busy});
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_kill();
    int req_v[17]   = '{1,0,0,0,1,0,0,0,1,0,0,0,1,0,0,0,0};
    int kill_v[17]  = '{0,1,0,0,0,0,0,0,0,0,0,1,1,0,0,0,0};
    int gnt_v[17]   = '{1,0,0,0,1,0,0,0,1,0,0,0,1,0,0,0,0};
    int rv_v[17]    = '{0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,1,0};
    int busy_v[17]  = '{0,1,1,1,0,1,1,1,0,1,1,1,0,1,1,1,0};
    apply_reset();
    if_addr   = 32'h80;
    mem_rdata = 32'hCAFE_0001;
    for (int c = 0; c < 17; c++) begin
      if_req  = req_v[c][0];
      if_kill = kill_v[c][0];
      @(negedge clk);
      checks++;
      if ({b_if_gnt, b_if_rvalid, b_busy} !== {gnt_v[c][0], rv_v[c][0], busy_v[c][0]}) begin
        failures++;
        $display("FAIL kill_seq cycle=%0d got gnt/rv/busy=%b exp=%b", c,
                 {b_if_gnt, b_if_rvalid, b_busy}, {gnt_v[c][0], rv_v[c][0], busy_v[c][0]});
      end
      if (rv_v[c] == 1) begin
        checks++;
        if (b_if_rdata !== 32'hCAFE_0001) begin
          failures++;
          $display("FAIL kill_rdata cycle=%0d got=%h exp=cafe0001", c, b_if_rdata);
        end
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_kill_data();
    apply_reset();
    d_req     = 1'b1;
    d_addr    = 32'h200;
    mem_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (b_d_gnt !== 1'b1 || b_mem_we !== 1'b0) begin
      failures++;
      $display("FAIL kdata_grant got gnt=%b we=%b exp gnt=1 we=0", b_d_gnt, b_mem_we);
    end
    next_cycle();
    d_req   = 1'b0;
    if_kill = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({b_d_rvalid, b_if_rvalid} !== 2'b10 || b_d_rdata !== 32'h1234_5678 || b_if_rdata !== 32'h0) begin
      failures++;
      $display("FAIL kdata_resp got drv/irv=%b drdata=%h irdata=%h exp 10 12345678 0",
               {b_d_rvalid, b_if_rvalid}, b_d_rdata, b_if_rdata);
    end
    next_cycle();
    if_kill = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h300;
    @(negedge clk);
    checks++;
    if (b_if_gnt !== 1'b1 || b_mem_addr !== 32'h300) begin
      failures++;
      $display("FAIL kdata_fetch_gnt got gnt=%b addr=%h exp gnt=1 addr=300", b_if_gnt, b_mem_addr);
    end
    next_cycle();
    if_req = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (b_if_rvalid !== 1'b1) begin
      failures++;
      $display("FAIL kdata_fetch_resp got rv=%b exp=1", b_if_rvalid);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    if_req    = 1'b1;
    if_addr   = 32'h44;
    mem_rdata = 32'hABCD_0000;
    @(negedge clk);
    checks++;
    if (b_if_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rmid_grant got=%b exp=1", b_if_gnt);
    end
    next_cycle();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({b_busy, b_if_rvalid, b_if_gnt, b_mem_en, b_d_rvalid} !== 5'b0 || b_mem_addr !== 32'h0) begin
        failures++;
        $display("FAIL rmid_quiet cycle=%0d got busy/rv/gnt/en/drv=%b addr=%h exp 00000 0", c,
                 {b_busy, b_if_rvalid, b_if_gnt, b_mem_en, b_d_rvalid}, b_mem_addr);
      end
      next_cycle();
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (b_if_gnt !== 1'b1 || b_mem_addr !== 32'h44) begin
      failures++;
      $display("FAIL rmid_regrant got gnt=%b addr=%h exp gnt=1 addr=44", b_if_gnt, b_mem_addr);
    end
    next_cycle();
    if_req = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (b_if_rvalid !== (c == 3)) begin
        failures++;
        $display("FAIL rmid_resp offset=%0d got rv=%b exp=%b", c, b_if_rvalid, (c == 3));
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_starvation();
    test_write();
    test_kill();
    test_kill_data();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
